oser_gearbox_tx: RTL
====================

# oser_gearbox_tx

Parallel-to-serial output gearbox feeding the IO output register (`OFD1S3AX` D input). It accepts WIDTH-bit words over a valid/ready handshake into a one-entry holding register and shifts them out one bit per SCLK. DOUT drives the output flop directly. Back-to-back words are serialized gaplessly; when no word is queued, the line is driven to a programmable idle level and a drain event is flagged.

## Interface
- WIDTH, 4, bits per word; legal range 2..16.
- MSB_FIRST, 0, 0 = bit 0 leaves first, 1 = bit WIDTH-1 leaves first.
- IDLE_VAL, 1'b0, level on DOUT when no word is shifting.
- SCLK  input  1  sole clock, rising edge; same clock as the downstream output flop.
- RST  input  1  asynchronous, active-high reset.
- DIN  input  WIDTH  parallel word; sampled when DVALID && DREADY.
- DVALID  input  1  DIN holds a valid word.
- DREADY  output  1  holding register empty; word accepted on the edge where DVALID && DREADY.
- DOUT  output  1  serial bit, registered, to the D input of the output flop.
- ACTIVE  output  1  high while DOUT carries a data bit.
- UNDERRUN  output  1  one-cycle pulse on the first idle cycle after a word completes with the hold register empty.

## Operation
- Storage:
  - hold register plus full flag;
  - WIDTH-bit shift register;
  - bit counter of width clog2(WIDTH), counting 0..WIDTH-1;
  - two states.
- DREADY = !hold_full. It depends only on registered state; there is no combinational DVALID→DREADY path.
- IDLE state:
  - DOUT = IDLE_VAL, ACTIVE = 0.
  - If hold_full: move the hold word into the shifter, output its first bit, clear hold_full, count = 0, go to SHIFT.
- SHIFT state:
  - DOUT = the current bit; ACTIVE = 1; count increments each cycle.
  - At count == WIDTH-1 (last bit) with hold_full: reload from hold, count = 0, stay in SHIFT. Output is gapless.
  - At count == WIDTH-1 with hold empty: go to IDLE, DOUT = IDLE_VAL next cycle, UNDERRUN pulses that cycle.
- Same-edge accept and reload: the accept on the reload edge of an already-full hold is impossible because DREADY is low. An accept into an empty hold on the same edge as a last-bit-without-hold still ends in IDLE; the word loads on the next edge. This is a one-cycle gap and UNDERRUN fires.
- Bit order: MSB_FIRST selects the shift direction. The ordering is fixed per instance.
- RST, asserted at any time (including mid-word):
  - discards the shifter and hold contents;
  - DOUT = IDLE_VAL, ACTIVE = 0, UNDERRUN = 0, DREADY = 1;
  - state = IDLE, count = 0.
  - No partial word is resumed.

## Timing
- Accept at edge N into an empty hold while IDLE:
  - edge N+1: DOUT = first bit, ACTIVE = 1;
  - last bit appears after edge N+WIDTH;
  - next edge: DOUT = IDLE_VAL if nothing is queued.
- DREADY rises one edge after the hold is consumed. Upstream may present the next word during the current word's second cycle.
- Sustained throughput: one word per WIDTH cycles with zero idle bits, provided each word is accepted at least one cycle before the current word's last bit.
- Pad latency: the output flop adds one more SCLK. Pin latency from accept = 2 cycles.

## Structure
- Package oser_pkg:
  - state enum {S_IDLE, S_SHIFT};
  - function computing counter width from WIDTH.
- Sub-module oser_hold_reg: one-entry holding register. Holds data and the full flag; exposes push (valid&&ready), pop (reload) and ready.
- Top module: shifter, counter, FSM, output registers.
- No other hierarchy.

## Test plan
- Reset: assert RST mid-word with WIDTH=4 → DOUT = 0 and ACTIVE = 0 immediately; DREADY = 1; after release, no residual bits are emitted.
- Single word: DIN = 4'b1011, LSB first → DOUT 1,1,0,1 on edges N+1..N+4; then 0; UNDERRUN pulses once at N+5.
- Back-to-back: 4'hA, 4'h5, 4'hF streamed with DVALID held high → 12 contiguous data bits, ACTIVE high throughout, UNDERRUN only after the last word.
- Backpressure: DVALID high continuously → DREADY low while the hold is full; no word lost or duplicated; the accept count equals the word count observed on DOUT.
- Late word: next word accepted exactly on the last-bit edge → one IDLE_VAL cycle, UNDERRUN = 1, then the word is emitted intact.
- Parameter sweep: WIDTH = 2 and 16, MSB_FIRST = 1, IDLE_VAL = 1 → bit order reversed, idle level high, gapless at WIDTH = 2.

Source files
------------

// File: rtl/oser_pkg.sv
// Shared types and helpers for the oser_gearbox_tx serializer.
package oser_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a WIDTH-bit word; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 32'd2) ? 32'd1 : 32'($clog2(width));
  endfunction

endpackage

// File: rtl/oser_hold_reg.sv
// One-entry holding register between the upstream handshake and the shifter.
module oser_hold_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  output logic             ready,
  output logic [WIDTH-1:0] data
);

  // ready is the registered empty flag, so the upstream sees no comb path from valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b1;
      data  <= '0;
    end else if (pop) begin
      ready <= 1'b1;
    end else if (push) begin
      ready <= 1'b0;
      data  <= din;
    end
  end

endmodule

// File: rtl/oser_gearbox_tx.sv
// Parallel-to-serial output gearbox: one WIDTH-bit word per WIDTH sclk cycles,
// gapless while words are queued, idle level plus underrun pulse otherwise.
module oser_gearbox_tx
  import oser_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic        IDLE_VAL  = 1'b0
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             dvalid,
  output logic             dready,
  output logic             dout,
  output logic             active,
  output logic             underrun
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_ready;
  logic             hold_full;
  logic             last_bit;
  logic             push;
  logic             pop;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign hold_full = !hold_ready;
  assign dready    = hold_ready;
  assign push      = dvalid && hold_ready;
  assign last_bit  = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
  assign pop       = hold_full && ((state == S_IDLE) || last_bit);

  oser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (sclk),
    .rst   (rst),
    .din   (din),
    .push  (push),
    .pop   (pop),
    .ready (hold_ready),
    .data  (hold_data)
  );

  // Shifter holds the bits not yet presented; dout always carries the current bit.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      dout     <= IDLE_VAL;
      active   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hold_full) begin
            state  <= S_SHIFT;
            cnt    <= '0;
            dout   <= head(hold_data);
            shreg  <= advance(hold_data);
            active <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            cnt <= '0;
            if (hold_full) begin
              dout  <= head(hold_data);
              shreg <= advance(hold_data);
            end else begin
              state    <= S_IDLE;
              dout     <= IDLE_VAL;
              active   <= 1'b0;
              underrun <= 1'b1;
            end
          end else begin
            cnt   <= cnt + CW'(1);
            dout  <= head(shreg);
            shreg <= advance(shreg);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
